// File: rtl/packet_writer_testbench_pkg.sv
// Shared widths, FSM states and the write-request beat layout for the packet writer.
// Pure declarations; no timing or flow control of its own.
package packet_writer_testbench_pkg;

  localparam int DATA_W         = 8;
  localparam int WORDS_PER_LINE = 2;
  localparam int LINES_PER_PAGE = 4;
  localparam int NUM_PAGES      = 4;
  localparam int WRITE_SLOT     = 0;
  localparam int PCOUNT_W       = 9;
  localparam int LEN_W          = 16;
  localparam int PID_W          = 16;
  localparam int LINE_W         = 2;
  localparam int PAGE_W         = 2;
  // A 16-bit length needs at most 32768 two-byte beats.
  localparam int BEAT_W         = 15;

  localparam logic [PCOUNT_W-1:0] PCOUNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic                                  slot;
    logic [PAGE_W-1:0]                     page_num;
    logic [LINE_W-1:0]                     line;
    logic [WORDS_PER_LINE-1:0][DATA_W-1:0] data;
  } wr_req_t;

  // Pages touched by a packet whose final beat had index last_idx, clamped to the counter range.
  function automatic logic [PCOUNT_W-1:0] sat_pages(input logic [BEAT_W-1:0] last_idx);
    logic [BEAT_W-1:0] pages;
    pages = (last_idx >> 2) + BEAT_W'(1);
    if (pages > BEAT_W'(PCOUNT_MAX)) begin
      return PCOUNT_MAX;
    end
    return pages[PCOUNT_W-1:0];
  endfunction

endpackage

// File: rtl/packet_writer_testbench_if.sv
// Descriptor, write-request and page-count signals of the packet writer.
// Master drives descriptors and observes results; slave is the writer itself.
interface packet_writer_testbench_if;
  import packet_writer_testbench_pkg::*;

  logic                io_sendPacket_valid;
  logic                io_sendPacket_ready;
  logic [LEN_W-1:0]    io_sendPacket_bits_length;
  logic [PID_W-1:0]    io_sendPacket_bits_pid;
  logic                io_sendPacket_bits_packetGood;
  logic                io_writeReqOut_valid;
  logic                io_writeReqOut_bits_slot;
  logic [PAGE_W-1:0]   io_writeReqOut_bits_page_pageNum;
  logic [LINE_W-1:0]   io_writeReqOut_bits_line;
  logic [DATA_W-1:0]   io_writeReqOut_bits_data_0;
  logic [DATA_W-1:0]   io_writeReqOut_bits_data_1;
  logic                io_error;
  logic                io_writePageCount_valid;
  logic [PCOUNT_W-1:0] io_writePageCount_bits;

  modport master (
    output io_sendPacket_valid, io_sendPacket_bits_length, io_sendPacket_bits_pid,
           io_sendPacket_bits_packetGood,
    input  io_sendPacket_ready, io_writeReqOut_valid, io_writeReqOut_bits_slot,
           io_writeReqOut_bits_page_pageNum, io_writeReqOut_bits_line,
           io_writeReqOut_bits_data_0, io_writeReqOut_bits_data_1, io_error,
           io_writePageCount_valid, io_writePageCount_bits
  );

  modport slave (
    input  io_sendPacket_valid, io_sendPacket_bits_length, io_sendPacket_bits_pid,
           io_sendPacket_bits_packetGood,
    output io_sendPacket_ready, io_writeReqOut_valid, io_writeReqOut_bits_slot,
           io_writeReqOut_bits_page_pageNum, io_writeReqOut_bits_line,
           io_writeReqOut_bits_data_0, io_writeReqOut_bits_data_1, io_error,
           io_writePageCount_valid, io_writePageCount_bits
  );

endinterface

// File: rtl/packet_writer_testbench_byte_gen.sv
// Produces the two payload bytes of one beat from pid and beat index, plus a last-beat flag.
// Combinational, zero latency; no flow control.
module packet_byte_gen
  import packet_writer_testbench_pkg::*;
(
  input  logic [DATA_W-1:0] pid_lsb,
  input  logic [LEN_W-1:0]  length,
  input  logic [BEAT_W-1:0] beat_idx,
  output logic [DATA_W-1:0] byte_0,
  output logic [DATA_W-1:0] byte_1,
  output logic              last
);

  logic [LEN_W:0] k0;
  logic [LEN_W:0] k1;

  always_comb begin
    k0     = {1'b0, beat_idx, 1'b0};
    k1     = k0 + (LEN_W+1)'(1);
    byte_0 = pid_lsb + k0[DATA_W-1:0];
    byte_1 = '0;
    // Odd-length packets pad the second byte of the final beat with zero.
    if (k1 < {1'b0, length}) begin
      byte_1 = pid_lsb + k1[DATA_W-1:0];
    end
    last = ((k0 + (LEN_W+1)'(2)) >= {1'b0, length});
  end

endmodule

// File: rtl/packet_writer_testbench.sv
// Accepts a packet descriptor and writes its generated bytes as line beats into a paged pool.
// First beat one cycle after accept, one beat per cycle; ready low until the cycle after DONE.
module packet_writer_testbench
  import packet_writer_testbench_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  packet_writer_testbench_if.slave io
);

  state_t              state_q, state_d;
  wr_req_t             req_q, req_d;
  logic                req_vld_q, req_vld_d;
  logic                last_q, last_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   pid_q, pid_d;
  logic                good_q, good_d;
  logic [PAGE_W-1:0]   page_q, page_d;
  logic [PAGE_W-1:0]   start_page_q, start_page_d;
  logic                err_q, err_d;
  logic                ready_q, ready_d;
  logic                pcnt_vld_q, pcnt_vld_d;
  logic [PCOUNT_W-1:0] pcnt_q, pcnt_d;

  logic [DATA_W-1:0]   gen_pid;
  logic [LEN_W-1:0]    gen_len;
  logic [BEAT_W-1:0]   gen_idx;
  logic [DATA_W-1:0]   gen_b0;
  logic [DATA_W-1:0]   gen_b1;
  logic                gen_last;
  logic                accept;

  // In IDLE the generator looks at the live descriptor so beat 0 is ready at accept time.
  always_comb begin
    if (state_q == ST_IDLE) begin
      gen_pid = io.io_sendPacket_bits_pid[DATA_W-1:0];
      gen_len = io.io_sendPacket_bits_length;
      gen_idx = '0;
    end else begin
      gen_pid = pid_q;
      gen_len = len_q;
      gen_idx = beat_q + BEAT_W'(1);
    end
  end

  packet_byte_gen u_byte_gen (
    .pid_lsb  (gen_pid),
    .length   (gen_len),
    .beat_idx (gen_idx),
    .byte_0   (gen_b0),
    .byte_1   (gen_b1),
    .last     (gen_last)
  );

  assign accept = (state_q == ST_IDLE) && ready_q && io.io_sendPacket_valid;

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    req_vld_d    = req_vld_q;
    last_d       = last_q;
    beat_d       = beat_q;
    len_d        = len_q;
    pid_d        = pid_q;
    good_d       = good_q;
    page_d       = page_q;
    start_page_d = start_page_q;
    err_d        = err_q;
    ready_d      = ready_q;
    pcnt_vld_d   = 1'b0;
    pcnt_d       = pcnt_q;

    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (accept) begin
          if (io.io_sendPacket_bits_length == '0) begin
            err_d = 1'b1;
          end else begin
            len_d          = io.io_sendPacket_bits_length;
            pid_d          = io.io_sendPacket_bits_pid[DATA_W-1:0];
            good_d         = io.io_sendPacket_bits_packetGood;
            start_page_d   = page_q;
            beat_d         = '0;
            req_vld_d      = 1'b1;
            req_d.slot     = 1'(WRITE_SLOT);
            req_d.page_num = page_q;
            req_d.line     = '0;
            req_d.data[0]  = gen_b0;
            req_d.data[1]  = gen_b1;
            last_d         = gen_last;
            ready_d        = 1'b0;
            state_d        = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        if (last_q) begin
          req_vld_d = 1'b0;
          req_d     = '0;
          // Packets always end on a page boundary, so the next one starts on a fresh page.
          page_d    = req_q.page_num + PAGE_W'(1);
          state_d   = ST_DONE;
          if (good_q) begin
            pcnt_vld_d = 1'b1;
            pcnt_d     = sat_pages(beat_q);
          end
        end else begin
          beat_d        = beat_q + BEAT_W'(1);
          req_d.line    = req_q.line + LINE_W'(1);
          if (req_q.line == LINE_W'(LINES_PER_PAGE - 1)) begin
            req_d.page_num = req_q.page_num + PAGE_W'(1);
          end
          req_d.data[0] = gen_b0;
          req_d.data[1] = gen_b1;
          last_d        = gen_last;
        end
      end

      ST_DONE: begin
        // A dropped packet hands its pages back by rewinding to where it started.
        if (!good_q) begin
          page_d = start_page_q;
        end
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        ready_d   = 1'b1;
        req_vld_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      req_q        <= '0;
      req_vld_q    <= 1'b0;
      last_q       <= 1'b0;
      beat_q       <= '0;
      len_q        <= '0;
      pid_q        <= '0;
      good_q       <= 1'b0;
      page_q       <= '0;
      start_page_q <= '0;
      err_q        <= 1'b0;
      ready_q      <= 1'b1;
      pcnt_vld_q   <= 1'b0;
      pcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      req_vld_q    <= req_vld_d;
      last_q       <= last_d;
      beat_q       <= beat_d;
      len_q        <= len_d;
      pid_q        <= pid_d;
      good_q       <= good_d;
      page_q       <= page_d;
      start_page_q <= start_page_d;
      err_q        <= err_d;
      ready_q      <= ready_d;
      pcnt_vld_q   <= pcnt_vld_d;
      pcnt_q       <= pcnt_d;
    end
  end

  assign io.io_sendPacket_ready              = ready_q;
  assign io.io_writeReqOut_valid             = req_vld_q;
  assign io.io_writeReqOut_bits_slot         = req_q.slot;
  assign io.io_writeReqOut_bits_page_pageNum = req_q.page_num;
  assign io.io_writeReqOut_bits_line         = req_q.line;
  assign io.io_writeReqOut_bits_data_0       = req_q.data[0];
  assign io.io_writeReqOut_bits_data_1       = req_q.data[1];
  assign io.io_error                         = err_q;
  assign io.io_writePageCount_valid          = pcnt_vld_q;
  assign io.io_writePageCount_bits           = pcnt_q;

endmodule

// File: tb/tb_packet_writer_testbench.sv
// Scoreboard bench: descriptors push expected beats/page counts, a negedge monitor pops and compares.
module tb_packet_writer_testbench;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  packet_writer_testbench_if bus ();

  packet_writer_testbench dut (
    .clock (clk),
    .reset (rst),
    .io    (bus)
  );

  typedef struct {
    int page;
    int line;
    int d0;
    int d1;
  } beat_t;

  beat_t exp_q[$];
  int    pc_q[$];
  int    model_page = 0;
  int    tests = 0;
  int    fails = 0;

  // Reference: bytes are pid+k, beats fill lines 0..3 of consecutive pages from the start page.
  task automatic push_model(input int len, input int pid, input bit good);
    int beats;
    int pages;
    beat_t b;
    beats = (len + 1) / 2;
    for (int k = 0; k < beats; k++) begin
      b.page = (model_page + k / 4) % 4;
      b.line = k % 4;
      b.d0   = (pid + 2 * k) % 256;
      b.d1   = (2 * k + 1 < len) ? (pid + 2 * k + 1) % 256 : 0;
      exp_q.push_back(b);
    end
    pages = (beats + 3) / 4;
    if (good) begin
      pc_q.push_back(pages > 511 ? 511 : pages);
      model_page = (model_page + pages) % 4;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.io_writeReqOut_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL beat: unexpected beat page=%0d line=%0d", bus.io_writeReqOut_bits_page_pageNum,
                   bus.io_writeReqOut_bits_line);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (bus.io_writeReqOut_bits_slot !== 1'b0 ||
              int'(bus.io_writeReqOut_bits_page_pageNum) != e.page ||
              int'(bus.io_writeReqOut_bits_line) != e.line ||
              int'(bus.io_writeReqOut_bits_data_0) != e.d0 ||
              int'(bus.io_writeReqOut_bits_data_1) != e.d1) begin
            fails++;
            $display("FAIL beat: got slot=%0d page=%0d line=%0d d=%02h,%02h expected slot=0 page=%0d line=%0d d=%02h,%02h",
                     bus.io_writeReqOut_bits_slot, bus.io_writeReqOut_bits_page_pageNum,
                     bus.io_writeReqOut_bits_line, bus.io_writeReqOut_bits_data_0,
                     bus.io_writeReqOut_bits_data_1, e.page, e.line, e.d0, e.d1);
          end
        end
      end
      if (bus.io_writePageCount_valid) begin
        tests++;
        if (pc_q.size() == 0) begin
          fails++;
          $display("FAIL page_count: unexpected pulse value %0d", bus.io_writePageCount_bits);
        end else begin
          int e;
          e = pc_q.pop_front();
          if (int'(bus.io_writePageCount_bits) != e) begin
            fails++;
            $display("FAIL page_count: got %0d expected %0d", bus.io_writePageCount_bits, e);
          end
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.io_sendPacket_ready && n < 20000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.io_sendPacket_ready) begin
      tests++;
      fails++;
      $display("FAIL %s: ready timeout got 0 expected 1", name);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 either right after accept or once idle again.
  task automatic send(input int len, input int pid, input bit good, input bit wait_done);
    wait_ready("send_pre");
    bus.io_sendPacket_valid           = 1'b1;
    bus.io_sendPacket_bits_length     = 16'(len);
    bus.io_sendPacket_bits_pid        = 16'(pid);
    bus.io_sendPacket_bits_packetGood = good;
    if (len != 0) push_model(len, pid % 256, good);
    @(posedge clk);
    #1;
    bus.io_sendPacket_valid = 1'b0;
    if (len != 0) begin
      check("first_beat_latency", bus.io_writeReqOut_valid, 1);
      check("ready_low_in_write", bus.io_sendPacket_ready, 0);
    end else begin
      check("zero_len_error", bus.io_error, 1);
      check("zero_len_ready", bus.io_sendPacket_ready, 1);
    end
    if (wait_done) wait_ready("send_done");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.io_sendPacket_valid           = 1'b0;
    bus.io_sendPacket_bits_length     = '0;
    bus.io_sendPacket_bits_pid        = '0;
    bus.io_sendPacket_bits_packetGood = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_ready", bus.io_sendPacket_ready, 1);
    check("rst_wr_valid", bus.io_writeReqOut_valid, 0);
    check("rst_error", bus.io_error, 0);
    check("rst_pc_valid", bus.io_writePageCount_valid, 0);
    check("rst_data", {bus.io_writeReqOut_bits_data_0, bus.io_writeReqOut_bits_data_1}, 0);
    check("rst_addr", {bus.io_writeReqOut_bits_page_pageNum, bus.io_writeReqOut_bits_line}, 0);

    send(128, 0, 1'b1, 1'b1);
    send(5, 16'h0010, 1'b1, 1'b1);
    send(3, 16'h0077, 1'b0, 1'b1);
    send(7, 16'h0005, 1'b1, 1'b1);
    check("no_error_yet", bus.io_error, 0);

    // Valid held high across the whole packet: second descriptor must wait for ready.
    bus.io_sendPacket_valid           = 1'b1;
    bus.io_sendPacket_bits_length     = 16'd6;
    bus.io_sendPacket_bits_pid        = 16'h1220;
    bus.io_sendPacket_bits_packetGood = 1'b1;
    push_model(6, 16'h20, 1'b1);
    @(posedge clk);
    #1;
    bus.io_sendPacket_bits_length = 16'd4;
    bus.io_sendPacket_bits_pid    = 16'h0040;
    check("hold_first_beat", bus.io_writeReqOut_valid, 1);
    for (int c = 1; c <= 4; c++) begin
      check("hold_ready_low", bus.io_sendPacket_ready, 0);
      @(posedge clk);
      #1;
    end
    check("hold_ready_back", bus.io_sendPacket_ready, 1);
    push_model(4, 16'h40, 1'b1);
    @(posedge clk);
    #1;
    bus.io_sendPacket_valid = 1'b0;
    check("hold_second_beat", bus.io_writeReqOut_valid, 1);
    wait_ready("hold_done");

    for (int i = 0; i < 20; i++) begin
      send(int'($urandom_range(1, 80)), int'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)), 1'b1);
    end

    send(4100, 16'h00A5, 1'b1, 1'b1);

    send(0, 16'h0001, 1'b1, 1'b1);
    send(9, 16'h0002, 1'b1, 1'b1);
    check("error_sticky", bus.io_error, 1);

    send(60, 16'h0050, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    pc_q.delete();
    model_page = 0;
    @(posedge clk);
    #1;
    check("midrst_wr_valid", bus.io_writeReqOut_valid, 0);
    check("midrst_ready", bus.io_sendPacket_ready, 1);
    check("midrst_error", bus.io_error, 0);
    check("midrst_pc_valid", bus.io_writePageCount_valid, 0);
    rst = 1'b0;
    send(9, 16'h0033, 1'b1, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    check("beats_drained", exp_q.size(), 0);
    check("counts_drained", pc_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/packet_writer_testbench.md
Name: packet_writer_testbench

Overview:
- Self-contained packet-writer harness: accepts a packet descriptor (length, pid, good flag), generates the packet byte stream internally, and writes it into a paged buffer as line-wide write requests.
- Reports the pages consumed per good packet and flags illegal requests.
- Sits at the top of the packet-buffer verification environment; downstream buffer memory is modelled only by the write-request port.

Parameters:
- DATA_W, 8, bits per data byte.
- WORDS_PER_LINE, 2, bytes per write beat (data_0, data_1).
- LINES_PER_PAGE, 4, lines per page (line field 2 bits).
- NUM_PAGES, 4, pages in pool (pageNum field 2 bits).
- WRITE_SLOT, 0, constant slot id driven on writeReqOut.
- PCOUNT_W, 9, page-count width.

Ports:
- clock  in  1  single clock.
- reset  in  1  synchronous, active-high.
- io_sendPacket_valid  in  1  descriptor valid.
- io_sendPacket_ready  out  1  harness idle, can accept.
- io_sendPacket_bits_length  in  16  packet length in bytes.
- io_sendPacket_bits_pid  in  16  packet id, seeds data.
- io_sendPacket_bits_packetGood  in  1  1 = good packet, 0 = drop after write.
- io_writeReqOut_valid  out  1  write request valid.
- io_writeReqOut_bits_slot  out  1  = WRITE_SLOT.
- io_writeReqOut_bits_page_pageNum  out  2  target page.
- io_writeReqOut_bits_line  out  2  target line within page.
- io_writeReqOut_bits_data_0  out  8  byte 2k of packet.
- io_writeReqOut_bits_data_1  out  8  byte 2k+1 (0 if beyond length).
- io_error  out  1  sticky error flag.
- io_writePageCount_valid  out  1  one-cycle pulse at good-packet end.
- io_writePageCount_bits  out  9  pages used by that packet.

Behaviour:
- Reset: ready=1, all valids 0, all data/addr outputs 0, error 0, page pointer 0, state IDLE.
- States IDLE, WRITE, DONE. Accept in IDLE on valid&&ready; latch length, pid, good; ready=0 outside IDLE.
- length==0: not written, error set (sticky until reset), stays IDLE.
- WRITE: first writeReqOut_valid the cycle after acceptance; one beat per cycle, no backpressure; beats = ceil(length/2).
- Data: byte k = (pid[7:0] + k) mod 256; padding byte in odd-length final beat = 0.
- Addressing: each packet starts at line 0 of current page pointer; line increments per beat; on line 3 -> 0, page = (page+1) mod NUM_PAGES.
- After last beat: page pointer advances to next page (packet ends on page boundary); pages used = ceil(beats/4).
- DONE (one cycle after last beat): if good, writePageCount_valid=1 with pages used, pointer kept; if not good, no pulse, page pointer restored to packet start page. Return to IDLE; ready=1 next cycle.
- Page count saturates at 511.
- Reset mid-packet aborts immediately; no pulse, pointer to 0.
- Descriptor inputs ignored when ready=0.

Decomposition:
- Package: widths/params above, state enum, write-request struct (slot, pageNum, line, data[2]).
- One sub-module natural: packet_byte_gen (pid/length -> 2-byte beats with last flag); FSM, addressing and page count stay in top.

Test Plan:
- Reset then length=128, pid=0, good=1 -> 64 beats, lines 0..3 repeating, pages 0,1,2,3,0..., data_0 of beat k = 2k; one pageCount pulse =16; error 0.
- length=5, pid=0x10 -> 3 beats: (10,11),(12,13),(14,00), page 0, lines 0-2; pageCount=1; next packet starts page 1 line 0.
- length=3, good=0 -> 2 beats on page P, no pageCount pulse; next packet starts again at page P.
- length=0 -> no writes, error=1 and stays 1 until reset.
- valid held during WRITE -> ignored; second accepted only after ready returns (cycle after DONE).
- reset asserted mid-WRITE -> next cycle valid=0, ready=1, error=0, next packet at page 0.
